multdiv_sequencer: RTL and testbench
====================================

// Module: multdiv_sequencer
// PURPOSE
//   Control FSM for the iterative multiply/divide unit. Accepts start pulses, sequences
//   the shift/add datapath through load, N iteration steps and a final fix-up cycle, and
//   flags result-ready / exception. Owns the 6-bit step counter; datapath only obeys strobes.
// PARAMETERS
//   MULT_STEPS  32  iteration cycles for a multiply (1..63)
//   DIV_STEPS   32  iteration cycles for a divide (1..63)
//   CNT_W       6   step counter width; must hold max(MULT_STEPS,DIV_STEPS)-1
// PORTS
//   clock            in   1      single clock, rising edge
//   reset            in   1      asynchronous, active-low reset
//   ctrl_mult        in   1      1-cycle start pulse, multiply
//   ctrl_div         in   1      1-cycle start pulse, divide
//   divisor_zero     in   1      datapath: latched divisor == 0, valid from the LOAD cycle on
//   dp_early_done    in   1      datapath: remaining multiplier bits all zero
//   dp_load          out  1      latch operands, clear accumulator
//   dp_step          out  1      perform one shift/add or shift/subtract iteration
//   dp_is_div        out  1      op select held for whole operation (0=mult, 1=div)
//   dp_finish        out  1      final sign-correction / remainder fix cycle
//   step_count       out  CNT_W  current iteration index
//   busy             out  1      operation in flight (LOAD..FIX)
//   data_result_rdy  out  1      1-cycle pulse, result valid on datapath output
//   data_exception   out  1      qualifies data_result_rdy; 1 = divide by zero
// BEHAVIOUR
//   - States: IDLE, LOAD, RUN, FIX, DONE. Outputs are decoded from registered state only.
//   - Reset (reset==0, async): state=IDLE; all outputs 0; step_count=0; dp_is_div=0.
//   - IDLE: start pulse -> LOAD; dp_is_div captured (1 for div, 0 for mult).
//   - ctrl_mult & ctrl_div in the same cycle: multiply wins.
//   - LOAD (1 cycle, dp_load=1, busy=1): div & divisor_zero -> DONE with exception;
//     else -> RUN, step_count cleared to 0.
//   - RUN (dp_step=1, busy=1): step_count increments each cycle; at STEPS-1 -> FIX.
//   - FIX (1 cycle, dp_finish=1, busy=1) -> DONE.
//   - DONE (1 cycle): data_result_rdy=1; data_exception=1 iff div-by-zero path; -> IDLE.
//   - Latency: start sampled at edge 0 -> data_result_rdy high in cycle STEPS+3
//     (35 for 32 steps); div-by-zero -> rdy+exception in cycle 2.
//   - Start pulse while busy or in DONE: aborts current op, re-enters LOAD next cycle
//     with the new op; no rdy pulse for the aborted op.
//   - step_count never wraps; holds last value in FIX/DONE/IDLE until next LOAD clears it.
//   - Async reset mid-operation: immediate return to IDLE, no rdy pulse, no exception.
// CONFIGURATION
//   MULTDIV_EARLY_EXIT_EN defined: in RUN with dp_is_div=0, dp_early_done=1 -> FIX at
//     the next edge regardless of step_count (datapath handles remaining shift in FIX).
//   Not defined: dp_early_done ignored; multiply always runs MULT_STEPS cycles.
//   dp_early_done never affects divides in either build.
// STRUCTURE
//   Package multdiv_pkg: state enum (IDLE/LOAD/RUN/FIX/DONE), MULT_STEPS/DIV_STEPS
//     defaults, CNT_W, op-select encoding; shared with the datapath and bench.
//   Sub-module multdiv_step_counter: CNT_W-bit up counter, sync clear + enable, async
//     active-low reset, terminal-count compare output; instantiated once.
// TESTING
//   1. reset low for 3 cycles mid-RUN -> all outputs 0 immediately, state IDLE, no rdy.
//   2. ctrl_mult pulse, 32 steps -> dp_load cycle 1, dp_step cycles 2..33, dp_finish 34,
//      rdy=1/exception=0 in cycle 35 only; step_count reaches 31.
//   3. ctrl_div pulse, divisor_zero=1 -> dp_load cycle 1, rdy=1 & exception=1 cycle 2, no dp_step.
//   4. ctrl_mult and ctrl_div same cycle -> dp_is_div=0, full 35-cycle multiply.
//   5. ctrl_div at RUN step 10 of a multiply -> LOAD next cycle, dp_is_div=1, single rdy at
//      +35 cycles from the second start, none for the first.
//   6. MULTDIV_EARLY_EXIT_EN, dp_early_done=1 at step 5 of multiply -> FIX next cycle,
//      rdy one cycle later; same stimulus without macro -> full 35-cycle latency.

Source files
------------

// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_pkg
// Brief    : Shared types and defaults for the multiply/divide sequencer,
//            its datapath and bench.
// Revision : 1.0  initial release
// ============================================================================
package multdiv_pkg;

    localparam int c_MULT_STEPS_DEF = 32;
    localparam int c_DIV_STEPS_DEF  = 32;
    localparam int c_CNT_W_DEF      = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

endpackage
`default_nettype wire

// File: rtl/multdiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_sequencer_if
// Brief    : Control/strobe bundle between the multdiv sequencer and its
//            environment (start requests in, datapath strobes out).
// Revision : 1.0  initial release
// ============================================================================
interface multdiv_sequencer_if
    import multdiv_pkg::*;
#(
    parameter int CNT_W = c_CNT_W_DEF
);
    logic             ctrl_mult;
    logic             ctrl_div;
    logic             divisor_zero;
    logic             dp_early_done;
    logic             dp_load;
    logic             dp_step;
    logic             dp_is_div;
    logic             dp_finish;
    logic [CNT_W-1:0] step_count;
    logic             busy;
    logic             data_result_rdy;
    logic             data_exception;

    modport master (
        output ctrl_mult, ctrl_div, divisor_zero, dp_early_done,
        input  dp_load, dp_step, dp_is_div, dp_finish, step_count,
               busy, data_result_rdy, data_exception
    );

    modport slave (
        input  ctrl_mult, ctrl_div, divisor_zero, dp_early_done,
        output dp_load, dp_step, dp_is_div, dp_finish, step_count,
               busy, data_result_rdy, data_exception
    );

endinterface
`default_nettype wire

// File: rtl/multdiv_step_counter.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_step_counter
// Brief    : Iteration counter with sync clear/enable and terminal compare.
// Revision : 1.0  initial release
// ============================================================================
module multdiv_step_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] last_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             w_tc;

    assign w_tc = (count_q == last_i);

    // Increment is blocked at terminal count so the index never wraps.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !w_tc) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = w_tc;

endmodule
`default_nettype wire

// File: rtl/multdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_sequencer
// Brief    : Control FSM for the iterative multiply/divide datapath.
//            Option macro MULTDIV_EARLY_EXIT_EN enables multiply early exit.
// Revision : 1.0  initial release
// ============================================================================
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int MULT_STEPS = c_MULT_STEPS_DEF,
    parameter int DIV_STEPS  = c_DIV_STEPS_DEF,
    parameter int CNT_W      = c_CNT_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    multdiv_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] c_MULT_LAST = CNT_W'(MULT_STEPS - 1);
    localparam logic [CNT_W-1:0] c_DIV_LAST  = CNT_W'(DIV_STEPS - 1);

    state_t           state_q;
    state_t           state_d;
    op_t              op_q;
    op_t              op_d;
    logic             exc_d;
    logic             dp_load_q;
    logic             dp_step_q;
    logic             dp_finish_q;
    logic             busy_q;
    logic             rdy_q;
    logic             exc_q;

    logic             w_start;
    logic             w_early;
    logic             w_tc;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic [CNT_W-1:0] w_last;

    assign w_start = bus.ctrl_mult | bus.ctrl_div;
    assign w_last  = (op_q == OP_DIV) ? c_DIV_LAST : c_MULT_LAST;

`ifdef MULTDIV_EARLY_EXIT_EN
    assign w_early = (state_q == ST_RUN) && (op_q == OP_MULT) && bus.dp_early_done;
`else
    logic w_unused_early_done;
    assign w_unused_early_done = bus.dp_early_done;
    assign w_early             = 1'b0;
`endif

    // A start in any state restarts from LOAD; multiply has priority.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        exc_d   = 1'b0;
        if (w_start) begin
            state_d = ST_LOAD;
            op_d    = bus.ctrl_mult ? OP_MULT : OP_DIV;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_LOAD: begin
                    if ((op_q == OP_DIV) && bus.divisor_zero) begin
                        state_d = ST_DONE;
                        exc_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN:  if (w_tc || w_early) state_d = ST_FIX;
                ST_FIX:  state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign w_cnt_clr = (state_q == ST_LOAD) && (state_d == ST_RUN);
    assign w_cnt_en  = (state_q == ST_RUN)  && (state_d == ST_RUN);

    // Strobes are registered from the next state so they line up with state_q.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_MULT;
            dp_load_q   <= 1'b0;
            dp_step_q   <= 1'b0;
            dp_finish_q <= 1'b0;
            busy_q      <= 1'b0;
            rdy_q       <= 1'b0;
            exc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            dp_load_q   <= (state_d == ST_LOAD);
            dp_step_q   <= (state_d == ST_RUN);
            dp_finish_q <= (state_d == ST_FIX);
            busy_q      <= (state_d == ST_LOAD) || (state_d == ST_RUN) || (state_d == ST_FIX);
            rdy_q       <= (state_d == ST_DONE);
            exc_q       <= (state_d == ST_DONE) && exc_d;
        end
    end

    multdiv_step_counter #(
        .CNT_W (CNT_W)
    ) u_step_counter (
        .clk_i   (clock),
        .rst_ni  (reset),
        .clr_i   (w_cnt_clr),
        .en_i    (w_cnt_en),
        .last_i  (w_last),
        .count_o (bus.step_count),
        .tc_o    (w_tc)
    );

    assign bus.dp_load         = dp_load_q;
    assign bus.dp_step         = dp_step_q;
    assign bus.dp_is_div       = (op_q == OP_DIV);
    assign bus.dp_finish       = dp_finish_q;
    assign bus.busy            = busy_q;
    assign bus.data_result_rdy = rdy_q;
    assign bus.data_exception  = exc_q;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multdiv_sequencer
// Brief    : Directed self-checking bench for multdiv_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_multdiv_sequencer;
    import multdiv_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multdiv_sequencer_if #(.CNT_W(6)) bus();

    multdiv_sequencer #(
        .MULT_STEPS (32),
        .DIV_STEPS  (32),
        .CNT_W      (6)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Per-operation observations, cycle 1 = first cycle after the start edge.
    int load_n, load_last, isdiv_at_load;
    int step_n, step_first, step_last, max_cnt;
    int fin_n, fin_cyc, busy_n;
    int rdy_n, rdy_cyc, exc_n, abort_cyc;

    task automatic start_op(input logic m, input logic d);
        @(negedge clk);
        bus.ctrl_mult = m;
        bus.ctrl_div  = d;
    endtask

    task automatic observe(input int ncyc, input int early_at, input int abort_at);
        load_n = 0; load_last = -1; isdiv_at_load = -1;
        step_n = 0; step_first = -1; step_last = -1; max_cnt = 0;
        fin_n = 0; fin_cyc = -1; busy_n = 0;
        rdy_n = 0; rdy_cyc = -1; exc_n = 0; abort_cyc = -1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            bus.ctrl_mult     = 1'b0;
            bus.ctrl_div      = 1'b0;
            bus.dp_early_done = 1'b0;
            if (bus.dp_load) begin
                load_n++; load_last = k; isdiv_at_load = int'(bus.dp_is_div);
            end
            if (bus.dp_step) begin
                step_n++; step_last = k;
                if (step_first < 0) step_first = k;
                if (int'(bus.step_count) > max_cnt) max_cnt = int'(bus.step_count);
            end
            if (bus.dp_finish) begin fin_n++; fin_cyc = k; end
            if (bus.busy) busy_n++;
            if (bus.data_result_rdy) begin rdy_n++; rdy_cyc = k; end
            if (bus.data_exception) exc_n++;
            if (early_at >= 0 && bus.dp_step && int'(bus.step_count) == early_at)
                bus.dp_early_done = 1'b1;
            if (abort_at >= 0 && abort_cyc < 0 && bus.dp_step && int'(bus.step_count) == abort_at) begin
                bus.ctrl_div = 1'b1;
                abort_cyc    = k;
            end
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_load"},   32'(bus.dp_load), 0);
        check({tag, "_step"},   32'(bus.dp_step), 0);
        check({tag, "_finish"}, 32'(bus.dp_finish), 0);
        check({tag, "_busy"},   32'(bus.busy), 0);
        check({tag, "_rdy"},    32'(bus.data_result_rdy), 0);
        check({tag, "_exc"},    32'(bus.data_exception), 0);
    endtask

    initial begin
        bus.ctrl_mult     = 1'b0;
        bus.ctrl_div      = 1'b0;
        bus.divisor_zero  = 1'b0;
        bus.dp_early_done = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_quiet("rst");
        check("rst_isdiv", 32'(bus.dp_is_div), 0);
        check("rst_cnt",   32'(bus.step_count), 0);
        rst_n = 1'b1;

        // Full multiply
        start_op(1'b1, 1'b0);
        observe(40, -1, -1);
        check("mul_load_n",  load_n, 1);
        check("mul_load_at", load_last, 1);
        check("mul_isdiv",   isdiv_at_load, 0);
        check("mul_step_n",  step_n, 32);
        check("mul_step_1st", step_first, 2);
        check("mul_step_end", step_last, 33);
        check("mul_fin_at",  fin_cyc, 34);
        check("mul_fin_n",   fin_n, 1);
        check("mul_busy_n",  busy_n, 34);
        check("mul_rdy_at",  rdy_cyc, 35);
        check("mul_rdy_n",   rdy_n, 1);
        check("mul_exc_n",   exc_n, 0);
        check("mul_maxcnt",  max_cnt, 31);
        check("mul_cnt_hold", 32'(bus.step_count), 31);

        // Divide by zero
        bus.divisor_zero = 1'b1;
        start_op(1'b0, 1'b1);
        observe(6, -1, -1);
        check("dz_load_n", load_n, 1);
        check("dz_isdiv",  isdiv_at_load, 1);
        check("dz_rdy_at", rdy_cyc, 2);
        check("dz_rdy_n",  rdy_n, 1);
        check("dz_exc_n",  exc_n, 1);
        check("dz_step_n", step_n, 0);
        check("dz_fin_n",  fin_n, 0);
        check("dz_busy_n", busy_n, 1);
        bus.divisor_zero = 1'b0;

        // Normal divide, early_done must be ignored
        start_op(1'b0, 1'b1);
        observe(40, 5, -1);
        check("div_isdiv",  isdiv_at_load, 1);
        check("div_step_n", step_n, 32);
        check("div_rdy_at", rdy_cyc, 35);
        check("div_rdy_n",  rdy_n, 1);
        check("div_exc_n",  exc_n, 0);

        // Simultaneous start: multiply wins
        start_op(1'b1, 1'b1);
        observe(40, -1, -1);
        check("both_isdiv",  isdiv_at_load, 0);
        check("both_step_n", step_n, 32);
        check("both_rdy_at", rdy_cyc, 35);
        check("both_rdy_n",  rdy_n, 1);

        // Abort a multiply at step 10 with a divide
        start_op(1'b1, 1'b0);
        observe(60, -1, 10);
        check("ab_abort_at", abort_cyc, 12);
        check("ab_load_n",   load_n, 2);
        check("ab_reload",   load_last - abort_cyc, 1);
        check("ab_isdiv",    isdiv_at_load, 1);
        check("ab_rdy_lat",  rdy_cyc - abort_cyc, 35);
        check("ab_rdy_n",    rdy_n, 1);
        check("ab_step_n",   step_n, 43);

        // Multiply with early_done at step 5
        start_op(1'b1, 1'b0);
        observe(40, 5, -1);
`ifdef MULTDIV_EARLY_EXIT_EN
        check("ee_fin_at", fin_cyc, 8);
        check("ee_rdy_at", rdy_cyc, 9);
        check("ee_step_n", step_n, 6);
        check("ee_maxcnt", max_cnt, 5);
`else
        check("ee_fin_at", fin_cyc, 34);
        check("ee_rdy_at", rdy_cyc, 35);
        check("ee_step_n", step_n, 32);
        check("ee_maxcnt", max_cnt, 31);
`endif
        check("ee_rdy_n", rdy_n, 1);

        // Async reset mid-RUN
        start_op(1'b1, 1'b0);
        observe(8, -1, -1);
        check("pre_rst_busy", 32'(bus.busy), 1);
        #1 rst_n = 1'b0;
        #1;
        check_quiet("arst");
        check("arst_cnt",   32'(bus.step_count), 0);
        check("arst_isdiv", 32'(bus.dp_is_div), 0);
        observe(3, -1, -1);
        check("arst_hold_rdy",  rdy_n, 0);
        check("arst_hold_busy", busy_n, 0);
        rst_n = 1'b1;
        observe(40, -1, -1);
        check("post_rst_rdy",  rdy_n, 0);
        check("post_rst_exc",  exc_n, 0);
        check("post_rst_busy", busy_n, 0);
        check("post_rst_load", load_n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
